// File: rtl/ram_copy_pkg.sv
// Shared constants and FSM state encoding for the RAM block copier.
package ram_copy_pkg;

  localparam int AW   = 12;
  localparam int DW   = 24;
  localparam int LENW = 13;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_RD   = 3'd1;
  localparam state_t ST_CAP  = 3'd2;
  localparam state_t ST_WR   = 3'd3;
  localparam state_t ST_DONE = 3'd4;

endpackage

// File: rtl/ram_block_copier_if.sv
// Control and RAM bus bundle for ram_block_copier; the checksum signal
// exists only when RAM_COPY_CHECKSUM_EN is defined.
interface ram_block_copier_if;
  import ram_copy_pkg::*;

  logic            start;
  logic [AW-1:0]   src_addr;
  logic [AW-1:0]   dst_addr;
  logic [LENW-1:0] len;
  logic            busy;
  logic            done;
  logic [AW-1:0]   ram_addr;
  logic            ram_re;
  logic            ram_we;
  logic [DW-1:0]   ram_din;
  logic [DW-1:0]   ram_dout;
`ifdef RAM_COPY_CHECKSUM_EN
  logic [DW-1:0]   checksum;

  modport master (
    input  start, src_addr, dst_addr, len, ram_dout,
    output busy, done, ram_addr, ram_re, ram_we, ram_din, checksum
  );
  modport slave (
    output start, src_addr, dst_addr, len, ram_dout,
    input  busy, done, ram_addr, ram_re, ram_we, ram_din, checksum
  );
`else
  modport master (
    input  start, src_addr, dst_addr, len, ram_dout,
    output busy, done, ram_addr, ram_re, ram_we, ram_din
  );
  modport slave (
    output start, src_addr, dst_addr, len, ram_dout,
    input  busy, done, ram_addr, ram_re, ram_we, ram_din
  );
`endif

endinterface

// File: rtl/ram_addr_gen.sv
// Source/destination pointers and remaining-word counter for the copier.
module ram_addr_gen
  import ram_copy_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [AW-1:0]   src_in,
  input  logic [AW-1:0]   dst_in,
  input  logic [LENW-1:0] len_in,
  output logic [AW-1:0]   src_ptr,
  output logic [AW-1:0]   dst_ptr,
  output logic            last
);

  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [LENW-1:0] rem_q, rem_d;

  // Pointers wrap naturally at AW bits.
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    if (load) begin
      src_d = src_in;
      dst_d = dst_in;
      rem_d = len_in;
    end else if (step) begin
      src_d = src_q + AW'(1);
      dst_d = dst_q + AW'(1);
      rem_d = rem_q - LENW'(1);
    end else begin
      rem_d = rem_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= {AW{1'b0}};
      dst_q <= {AW{1'b0}};
      rem_q <= {LENW{1'b0}};
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
    end
  end

  assign src_ptr = src_q;
  assign dst_ptr = dst_q;
  assign last    = (rem_q == LENW'(1));

endmodule

// File: rtl/ram_block_copier.sv
// Self-timed RAM block copy engine: read, capture, write per word.
// Optional running checksum of written words under RAM_COPY_CHECKSUM_EN.
module ram_block_copier
  import ram_copy_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  ram_block_copier_if.master bus
);

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          re_q, re_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic          load_s;
  logic          step_s;
  logic [AW-1:0] src_ptr_s;
  logic [AW-1:0] dst_ptr_s;
  logic          last_s;

  assign load_s = (state_q == ST_IDLE) && bus.start && (bus.len != {LENW{1'b0}});
  assign step_s = (state_q == ST_WR);

  ram_addr_gen u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_s),
    .step    (step_s),
    .src_in  (bus.src_addr),
    .dst_in  (bus.dst_addr),
    .len_in  (bus.len),
    .src_ptr (src_ptr_s),
    .dst_ptr (dst_ptr_s),
    .last    (last_s)
  );

  // Outputs are decided one cycle ahead so every RAM strobe comes from a flop;
  // the pointers step at the end of WR, hence the +1 when re-entering RD.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    re_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.len != {LENW{1'b0}}) begin
            state_d = ST_RD;
            busy_d  = 1'b1;
            re_d    = 1'b1;
            addr_d  = bus.src_addr;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        state_d = ST_CAP;
      end
      ST_CAP: begin
        state_d = ST_WR;
        we_d    = 1'b1;
        addr_d  = dst_ptr_s;
        data_d  = bus.ram_dout;
      end
      ST_WR: begin
        if (last_s) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RD;
          re_d    = 1'b1;
          addr_d  = src_ptr_s + AW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {AW{1'b0}};
      data_q  <= {DW{1'b0}};
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      re_q    <= re_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ram_re   = re_q;
  assign bus.ram_we   = we_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_din  = data_q;

`ifdef RAM_COPY_CHECKSUM_EN
  logic [DW-1:0] checksum_q, checksum_d;

  // data_q is the word being written during WR.
  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == ST_IDLE) && bus.start) begin
      checksum_d = {DW{1'b0}};
    end else if (state_q == ST_WR) begin
      checksum_d = checksum_q + data_q;
    end else begin
      checksum_d = checksum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= {DW{1'b0}};
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign bus.checksum = checksum_q;
`endif

endmodule

// File: tb/tb_ram_block_copier.sv
// Scoreboard bench for ram_block_copier with a behavioural RAM and copy model.
module tb_ram_block_copier;
  import ram_copy_pkg::*;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  ram_block_copier_if bus();

  ram_block_copier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  int  rd_q[$];
  wr_t wr_q[$];
  int  done_q[$];
  logic [DW-1:0] cs_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: write commits on the edge, read data valid the following cycle.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    if (bus.ram_re) bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every RAM access and done pulse must match the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ram_re || bus.ram_we) chk("re_we_exclusive", {31'd0, bus.ram_re & bus.ram_we}, 32'd0);
      if (bus.ram_re) begin
        if (rd_q.size() == 0) chk("unexpected_read", {20'd0, bus.ram_addr}, 32'hFFFF_FFFF);
        else chk("read_addr", {20'd0, bus.ram_addr}, rd_q.pop_front());
      end
      if (bus.ram_we) begin
        if (wr_q.size() == 0) chk("unexpected_write", {20'd0, bus.ram_addr}, 32'hFFFF_FFFF);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("write_addr", {20'd0, bus.ram_addr}, {20'd0, w.a});
          chk("write_data", {8'd0, bus.ram_din}, {8'd0, w.d});
        end
      end
      if (bus.done) begin
        chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
        if (done_q.size() == 0) chk("unexpected_done", cyc, 32'hFFFF_FFFF);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic preload(input int a, input logic [DW-1:0] d);
    pre_we   = 1'b1;
    pre_addr = a[AW-1:0];
    pre_data = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic cmp_mem(input string name);
    int bad;
    int first;
    bad   = 0;
    first = -1;
    for (int i = 0; i < 4096; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s mem_mismatches=%0d first_addr=%0d got=%0h exp=%0h",
               name, bad, first, mem[first], ref_mem[first]);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({name, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({name, "_re"},   {31'd0, bus.ram_re}, 32'd0);
    chk({name, "_we"},   {31'd0, bus.ram_we}, 32'd0);
    chk({name, "_addr"}, {20'd0, bus.ram_addr}, 32'd0);
    chk({name, "_din"},  {8'd0, bus.ram_din}, 32'd0);
`ifdef RAM_COPY_CHECKSUM_EN
    chk({name, "_cs"},   {8'd0, bus.checksum}, 32'd0);
`endif
  endtask

  // Expected behaviour: strictly ascending word-by-word copy, modulo 4096.
  task automatic copy(input int src, input int dst, input int len, input bit glitch, input string name);
    int  c;
    int  s;
    int  budget;
    wr_t w;
    @(negedge clk);
    c      = cyc;
    cs_exp = '0;
    for (int i = 0; i < len; i++) begin
      s   = (src + i) % 4096;
      w.a = 12'((dst + i) % 4096);
      w.d = ref_mem[s];
      ref_mem[w.a] = w.d;
      cs_exp = cs_exp + w.d;
      rd_q.push_back(s);
      wr_q.push_back(w);
    end
    done_q.push_back(c + 3 * len + 1);
    bus.start    = 1'b1;
    bus.src_addr = src[AW-1:0];
    bus.dst_addr = dst[AW-1:0];
    bus.len      = len[LENW-1:0];
    @(negedge clk);
    bus.start    = 1'b0;
    bus.src_addr = 12'($urandom);
    bus.dst_addr = 12'($urandom);
    bus.len      = 13'($urandom_range(1, 50));
    #1;
    chk({name, "_busy_after_start"}, {31'd0, bus.busy}, {31'd0, len != 0});
    budget = 3 * len + 20;
    for (int k = 0; k < budget; k++) begin
      if (rd_q.size() == 0 && wr_q.size() == 0 && done_q.size() == 0) break;
      @(negedge clk);
      #1;
      bus.start = (glitch && k == 0) ? 1'b1 : 1'b0;
    end
    bus.start = 1'b0;
    if (rd_q.size() != 0 || wr_q.size() != 0 || done_q.size() != 0) begin
      chk({name, "_timeout"}, rd_q.size() + wr_q.size() + done_q.size(), 32'd0);
      rd_q.delete();
      wr_q.delete();
      done_q.delete();
    end
    chk({name, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
`ifdef RAM_COPY_CHECKSUM_EN
    @(negedge clk);
    chk({name, "_checksum"}, {8'd0, bus.checksum}, {8'd0, cs_exp});
`endif
    @(negedge clk);
    cmp_mem({name, "_mem"});
  endtask

  initial begin
    int  c;
    int  s;
    wr_t w;
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    rst_n        = 1'b0;
    pre_we       = 1'b0;
    pre_addr     = '0;
    pre_data     = '0;
    bus.start    = 1'b0;
    bus.src_addr = '0;
    bus.dst_addr = '0;
    bus.len      = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 4096; i++) preload(i, 24'($urandom));

    for (int i = 0; i < 4; i++) preload(545 + i, 24'(64 + i));
    copy(545, 721, 4, 1'b0, "basic");

    copy(200, 300, 0, 1'b0, "len0");

    preload(4094, 24'd1);
    preload(4095, 24'd2);
    preload(0, 24'd3);
    preload(1, 24'd4);
    copy(4094, 10, 4, 1'b0, "wrap");

    copy(900, 950, 2, 1'b1, "restart_ignored");

    copy(100, 102, 6, 1'b0, "overlap");

    // Abort during the write of the second word of a four-word copy.
    @(negedge clk);
    c = cyc;
    for (int i = 0; i < 2; i++) begin
      s   = (1500 + i) % 4096;
      w.a = 12'((1600 + i) % 4096);
      w.d = ref_mem[s];
      if (i == 0) ref_mem[w.a] = w.d;
      rd_q.push_back(s);
      wr_q.push_back(w);
    end
    bus.start    = 1'b1;
    bus.src_addr = 12'd1500;
    bus.dst_addr = 12'd1600;
    bus.len      = 13'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_pending", rd_q.size() + wr_q.size(), 32'd0);
    rd_q.delete();
    wr_q.delete();
    repeat (3) @(negedge clk);
    cmp_mem("abort_mem");
    copy(1500, 1700, 3, 1'b0, "after_abort");

    preload(3000, 24'd78);
    preload(3001, 24'd64);
    preload(3002, 24'hFFFFFF);
    copy(3000, 3100, 3, 1'b0, "cs_wrap");
`ifdef RAM_COPY_CHECKSUM_EN
    chk("cs_wrap_const", {8'd0, bus.checksum}, 32'h0000_008D);
`endif

    for (int t = 0; t < 6; t++) copy($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(1, 40), 1'b0, "random");

    copy($urandom_range(0, 4095), $urandom_range(0, 4095), 4096, 1'b0, "full_array");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
